// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input block / downstream credit path and one output port arbiter.
interface output_port_arbiter_if #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8
);
  localparam int VCW = $clog2(VC_NUM);
  localparam int CW  = $clog2(BUFFER_SIZE + 1);

  logic [PORT_NUM-1:0]           request_i;
  logic [PORT_NUM-1:0][VCW-1:0]  request_vc_i;
  logic [PORT_NUM-1:0]           request_tail_i;
  logic                          credit_valid_i;
  logic [VCW-1:0]                credit_vc_i;
  logic [PORT_NUM-1:0]           grant_o;
  logic                          grant_valid_o;
  logic [VCW-1:0]                grant_vc_o;
  logic [VC_NUM-1:0][CW-1:0]     credit_count_o;
  logic                          locked_o;
  logic                          error_o;

  modport slave (
    input  request_i, request_vc_i, request_tail_i, credit_valid_i, credit_vc_i,
    output grant_o, grant_valid_o, grant_vc_o, credit_count_o, locked_o, error_o
  );

  modport master (
    output request_i, request_vc_i, request_tail_i, credit_valid_i, credit_vc_i,
    input  grant_o, grant_valid_o, grant_vc_o, credit_count_o, locked_o, error_o
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Output port switch arbiter: round-robin with wormhole lock and per-VC downstream credits.
// Optional OUTPUT_ARB_CREDIT_BYPASS_EN lets a returning credit qualify a grant in the same cycle.
module output_port_arbiter #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output_port_arbiter_if.slave  arb_if
);
  localparam int VCW = $clog2(VC_NUM);
  localparam int CW  = $clog2(BUFFER_SIZE + 1);
  localparam int PW  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     lock_port_q, lock_port_d;
  logic              error_q;
  logic [CW-1:0]     credit_q [VC_NUM];
  logic [CW-1:0]     credit_d [VC_NUM];

  logic [VC_NUM-1:0]   inc, dec, avail, ovf;
  logic [PORT_NUM-1:0] eligible;
  logic                rr_found;
  logic [PW-1:0]       rr_sel;
  logic [PW-1:0]       grant_sel;
  logic                grant_valid;
  logic                grant_tail;
  logic [VCW-1:0]      grant_vc;

  for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
    assign inc[gi] = arb_if.credit_valid_i && (arb_if.credit_vc_i == VCW'(gi));
    assign dec[gi] = grant_valid && (grant_vc == VCW'(gi));
    assign ovf[gi] = inc[gi] && !dec[gi] && (credit_q[gi] == CW'(BUFFER_SIZE));
`ifdef OUTPUT_ARB_CREDIT_BYPASS_EN
    assign avail[gi] = (credit_q[gi] != '0) || inc[gi];
`else
    assign avail[gi] = (credit_q[gi] != '0);
`endif
    assign credit_d[gi] = (inc[gi] && !dec[gi]) ?
                            ((credit_q[gi] == CW'(BUFFER_SIZE)) ? credit_q[gi] : credit_q[gi] + CW'(1)) :
                          (dec[gi] && !inc[gi]) ? credit_q[gi] - CW'(1) :
                          credit_q[gi];
    assign arb_if.credit_count_o[gi] = credit_q[gi];
  end

  for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
    assign eligible[gi]       = arb_if.request_i[gi] && avail[arb_if.request_vc_i[gi]];
    assign arb_if.grant_o[gi] = grant_valid && (grant_sel == PW'(gi));
  end

  // First eligible port at or after rr_ptr, wrapping modulo PORT_NUM.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = lock_port_q;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_port_d = lock_port_q;
    if (rst) begin
      if (state_q == IDLE) begin
        if (rr_found) begin
          grant_valid = 1'b1;
          grant_sel   = rr_sel;
        end
      end else if (eligible[lock_port_q]) begin
        grant_valid = 1'b1;
      end
    end
    grant_vc   = grant_valid ? arb_if.request_vc_i[grant_sel] : '0;
    grant_tail = arb_if.request_tail_i[grant_sel];
    if (grant_valid) begin
      if (grant_tail) begin
        state_d  = IDLE;
        rr_ptr_d = (grant_sel == PW'(PORT_NUM - 1)) ? '0 : grant_sel + PW'(1);
      end else begin
        state_d     = LOCKED;
        lock_port_d = grant_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_port_q <= '0;
      error_q     <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) credit_q[v] <= CW'(BUFFER_SIZE);
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_port_q <= lock_port_d;
      error_q     <= error_q | (|ovf);
      for (int v = 0; v < VC_NUM; v++) credit_q[v] <= credit_d[v];
    end
  end

  assign arb_if.grant_valid_o = grant_valid;
  assign arb_if.grant_vc_o    = grant_vc;
  assign arb_if.locked_o      = rst && (state_q == LOCKED);
  assign arb_if.error_o       = error_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed table-driven bench for output_port_arbiter (PORT_NUM=5, VC_NUM=2, BUFFER_SIZE=8).
module tb_output_port_arbiter;
  logic clk;
  logic rst;

  output_port_arbiter_if #(.PORT_NUM(5), .VC_NUM(2), .BUFFER_SIZE(8)) arb_if ();

  output_port_arbiter #(.PORT_NUM(5), .VC_NUM(2), .BUFFER_SIZE(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (arb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] req;
    logic [4:0] vc;
    logic [4:0] tail;
    logic       cv;
    logic       cvc;
    logic [4:0] g;
    logic       gvc;
    logic       lk;
    int         c0;
    int         c1;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic add(input logic [4:0] req, input logic [4:0] vc, input logic [4:0] tail,
                     input logic cv, input logic cvc, input logic [4:0] g, input logic gvc,
                     input logic lk, input int c0, input int c1, input logic err);
    vec_t v;
    v.req = req; v.vc = vc; v.tail = tail; v.cv = cv; v.cvc = cvc;
    v.g = g; v.gvc = gvc; v.lk = lk; v.c0 = c0; v.c1 = c1; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] req, input logic [4:0] vc, input logic [4:0] tail,
                       input logic cv, input logic cvc);
    arb_if.request_i      = req;
    arb_if.request_vc_i   = vc;
    arb_if.request_tail_i = tail;
    arb_if.credit_valid_i = cv;
    arb_if.credit_vc_i    = cvc;
  endtask

  initial begin
    rst = 1'b0;
    drive(5'b11111, 5'b00000, 5'b11111, 1'b0, 1'b0);

    // Reset / round robin / wormhole / drain to vc0=0
    add(5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 8, 8, 0);
    add(5'b10101, 5'b00000, 5'b11111, 0, 0, 5'b00001, 0, 0, 8, 8, 0);
    add(5'b10101, 5'b00000, 5'b11111, 0, 0, 5'b00100, 0, 0, 7, 8, 0);
    add(5'b10101, 5'b00000, 5'b11111, 0, 0, 5'b10000, 0, 0, 6, 8, 0);
    add(5'b10101, 5'b00000, 5'b11111, 0, 0, 5'b00001, 0, 0, 5, 8, 0);
    add(5'b01010, 5'b00000, 5'b00000, 0, 0, 5'b00010, 0, 0, 4, 8, 0);
    add(5'b01010, 5'b00000, 5'b00000, 0, 0, 5'b00010, 0, 1, 3, 8, 0);
    add(5'b01000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 1, 2, 8, 0);
    add(5'b01010, 5'b00000, 5'b00010, 0, 0, 5'b00010, 0, 1, 2, 8, 0);
    add(5'b01000, 5'b00000, 5'b01000, 0, 0, 5'b01000, 0, 0, 1, 8, 0);
    add(5'b00001, 5'b00000, 5'b00001, 0, 0, 5'b00000, 0, 0, 0, 8, 0);
    // Drain vc1 via port 2 while credits flow back on vc0
    for (int k = 0; k < 8; k++)
      add(5'b00100, 5'b00100, 5'b00100, 1, 0, 5'b00100, 1, 0, k, 8 - k, 0);
    add(5'b00100, 5'b00100, 5'b00100, 0, 0, 5'b00000, 0, 0, 8, 0, 0);
`ifdef OUTPUT_ARB_CREDIT_BYPASS_EN
    add(5'b00100, 5'b00100, 5'b00100, 1, 1, 5'b00100, 1, 0, 8, 0, 0);
    add(5'b00100, 5'b00100, 5'b00100, 0, 0, 5'b00000, 0, 0, 8, 0, 0);
`else
    add(5'b00100, 5'b00100, 5'b00100, 1, 1, 5'b00000, 0, 0, 8, 0, 0);
    add(5'b00100, 5'b00100, 5'b00100, 0, 0, 5'b00100, 1, 0, 8, 1, 0);
`endif
    // Overflow on vc0, then simultaneous grant+credit at count 5
    add(5'b00000, 5'b00000, 5'b00000, 1, 0, 5'b00000, 0, 0, 8, 0, 0);
    add(5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 8, 0, 1);
    add(5'b00001, 5'b00000, 5'b00001, 0, 0, 5'b00001, 0, 0, 8, 0, 1);
    add(5'b00001, 5'b00000, 5'b00001, 0, 0, 5'b00001, 0, 0, 7, 0, 1);
    add(5'b00001, 5'b00000, 5'b00001, 0, 0, 5'b00001, 0, 0, 6, 0, 1);
    add(5'b00001, 5'b00000, 5'b00001, 1, 0, 5'b00001, 0, 0, 5, 0, 1);
    add(5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 5, 0, 1);

    // Outputs gated during the reset cycle even with all ports requesting
    @(negedge clk);
    #1;
    check("rst_grant", -1, int'(arb_if.grant_o), 0);
    check("rst_gvalid", -1, int'(arb_if.grant_valid_o), 0);
    check("rst_locked", -1, int'(arb_if.locked_o), 0);
    $display("reset cycle: grant=%b locked=%b", arb_if.grant_o, arb_if.locked_o);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = 1'b1;
      drive(vecs[i].req, vecs[i].vc, vecs[i].tail, vecs[i].cv, vecs[i].cvc);
      #1;
      $display("vec %0d: req=%b grant=%b gvc=%0d locked=%b credits=%0d/%0d err=%b", i,
               vecs[i].req, arb_if.grant_o, arb_if.grant_vc_o, arb_if.locked_o,
               arb_if.credit_count_o[0], arb_if.credit_count_o[1], arb_if.error_o);
      check("grant", i, int'(arb_if.grant_o), int'(vecs[i].g));
      check("grant_valid", i, int'(arb_if.grant_valid_o), int'(|vecs[i].g));
      check("grant_vc", i, int'(arb_if.grant_vc_o), int'(vecs[i].gvc));
      check("locked", i, int'(arb_if.locked_o), int'(vecs[i].lk));
      check("credit0", i, int'(arb_if.credit_count_o[0]), vecs[i].c0);
      check("credit1", i, int'(arb_if.credit_count_o[1]), vecs[i].c1);
      check("error", i, int'(arb_if.error_o), int'(vecs[i].err));
    end

    // Reset in the middle of a locked packet (rr_ptr=1, so port 4 wins the scan)
    @(negedge clk);
    drive(5'b10000, 5'b00000, 5'b00000, 1'b0, 1'b0);
    #1;
    check("mid_head_grant", 100, int'(arb_if.grant_o), 5'b10000);
    @(negedge clk);
    #1;
    check("mid_locked", 101, int'(arb_if.locked_o), 1);
    check("mid_body_grant", 101, int'(arb_if.grant_o), 5'b10000);
    $display("locked packet: grant=%b locked=%b", arb_if.grant_o, arb_if.locked_o);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_grant", 102, int'(arb_if.grant_o), 0);
    check("mid_rst_locked", 102, int'(arb_if.locked_o), 0);
    $display("reset during packet: grant=%b locked=%b", arb_if.grant_o, arb_if.locked_o);
    @(negedge clk);
    rst = 1'b1;
    drive(5'b10001, 5'b00000, 5'b10001, 1'b0, 1'b0);
    #1;
    check("post_rst_c0", 103, int'(arb_if.credit_count_o[0]), 8);
    check("post_rst_c1", 103, int'(arb_if.credit_count_o[1]), 8);
    check("post_rst_err", 103, int'(arb_if.error_o), 0);
    check("post_rst_locked", 103, int'(arb_if.locked_o), 0);
    check("post_rst_grant", 103, int'(arb_if.grant_o), 5'b00001);
    $display("after reset: grant=%b credits=%0d/%0d err=%b", arb_if.grant_o,
             arb_if.credit_count_o[0], arb_if.credit_count_o[1], arb_if.error_o);

    @(negedge clk);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
